alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised, registered ALU for the datapath with valid/ready handshakes on input and output.
//  Single-cycle ops deliver one result per clock; optional iterative multiply takes WIDTH cycles.
//  Emits Z/N/C/V flags and a MATCH flag (result == MATCH_VALUE); MATCH drives MMIO store detect in the UC.
// PARAMETERS
//  WIDTH        32        operand/result width; power of two, >= 8
//  MATCH_VALUE  'hABCD    constant compared against result for match flag (WIDTH bits)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands/op valid
//  in_ready   out  1      block can accept (combinational from state/out regs)
//  op         in   4      operation code (alu_pkg::alu_op_t)
//  a, b       in   WIDTH  operands (two's complement)
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer takes result
//  result     out  WIDTH  registered result
//  z,n,c,v    out  1      zero, sign(result[MSB]), carry/no-borrow, signed overflow
//  match      out  1      result == MATCH_VALUE
//  err        out  1      op illegal (unassigned code, or MUL when not compiled in)
// BEHAVIOUR
//  Ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRA, 7 SRL, 8 SLT, 9 SLTU, 10 MUL; 11-15 illegal.
//  Shifts use b[$clog2(WIDTH)-1:0] only; upper bits of b ignored. SLT/SLTU result is 0 or 1.
//  c: ADD carry-out; SUB 1 when a >= b unsigned (no borrow). v: ADD/SUB signed overflow. c=v=0 for all other ops.
//  z/n/match always computed from the final result. Illegal op: result 0, z=1, err=1, still a normal transfer.
//  FSM: IDLE, MUL. in_ready = (state==IDLE) && (!out_valid || out_ready).
//  Accept = in_valid && in_ready. Non-MUL accepted: output regs load at that edge; out_valid=1 next cycle.
//  Back-to-back non-MUL ops at 1/clock while out_ready held high.
//  MUL accepted: IDLE->MUL, operands latched, cnt=0; one shift-add step per clock.
//  Result (low WIDTH bits of product, sign-agnostic) loads on the WIDTH-th MUL edge; MUL->IDLE.
//  That load happens only if !out_valid || out_ready; otherwise hold in MUL with cnt frozen at its terminal value.
//  out_valid clears on out_ready when no new load occurs the same edge. Simultaneous drain+load: new data wins, out_valid stays 1.
//  Output regs (result, flags, err) are stable while out_valid && !out_ready.
//  Reset (any time, incl. mid-MUL): state=IDLE, cnt=0, out_valid=0, result=0, z=n=c=v=match=err=0; partial product discarded.
//  After reset deassertion, in_ready=1.
// CONFIGURATION
//  ALU_MUL_EN defined: MUL implemented as above (instantiates alu_mul_iter).
//  ALU_MUL_EN undefined: no multiplier logic, FSM never leaves IDLE; op 10 treated as illegal (err=1, result 0, 1-cycle latency).
// STRUCTURE
//  alu_pkg: alu_op_t enum (codes above), OP_W=4, flag struct {z,n,c,v,match,err}.
//  Sub-module alu_mul_iter: WIDTH-step shift-add engine (start, step, done, product); only elaborated under ALU_MUL_EN.
//  Combinational op/flag logic stays in alu_pipe.
// TESTING
//  ADD a=32'h7FFF_FFFF b=1, out_ready=1 -> next cycle result 32'h8000_0000, n=1 v=1 c=0 z=0.
//  SUB a=5 b=5 -> result 0, z=1, c=1; ADD a=32'hABCC b=1 -> result 32'hABCD, match=1.
//  SRA a=32'h8000_0000 b=32'h0000_0024 -> shift 4, result 32'hF800_0000; SLL b=32 -> shift 0, result=a.
//  Stream 8 ADDs with in_valid and out_ready high -> 8 results on 8 consecutive cycles, in order.
//  out_ready=0 for 5 cycles with result pending -> in_ready=0, result/flags stable; drain -> next accept same cycle.
//  MUL 32'hFFFF_FFFF*3 (ALU_MUL_EN) -> out_valid 32 cycles after accept, result 32'hFFFF_FFFD.
//  Reset mid-MUL -> out_valid=0 and in_ready=1 after release.
//  Without ALU_MUL_EN -> MUL gives err=1, result=0 next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the registered ALU: op codes, flag bundle and code width.
package alu_pkg;

   localparam int OP_W = 4;

   typedef enum logic [OP_W-1:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_SLL  = 4'd5,
      OP_SRA  = 4'd6,
      OP_SRL  = 4'd7,
      OP_SLT  = 4'd8,
      OP_SLTU = 4'd9,
      OP_MUL  = 4'd10
   } alu_op_t;

   typedef struct packed {
      logic z;
      logic n;
      logic c;
      logic v;
      logic match;
      logic err;
   } alu_flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per step, low WIDTH bits kept.
// product is combinational and already includes the step for the current cnt.
module alu_mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             step,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [CW-1:0]    cnt;

   assign product = acc + (mplier[0] ? mcand : '0);
   assign done    = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
      end else if (start) begin
         mcand  <= a;
         mplier <= b;
         acc    <= '0;
         cnt    <= '0;
      end else if (step) begin
         acc    <= product;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes and Z/N/C/V/MATCH/ERR flags.
// Optional iterative multiply is compiled in with `define ALU_MUL_EN.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] MATCH_VALUE = WIDTH'('hABCD)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             z,
   output logic             n,
   output logic             c,
   output logic             v,
   output logic             match,
   output logic             err
);

   localparam int SHW = $clog2(WIDTH);
   localparam int MSB = WIDTH - 1;

   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t           state, state_nxt;
   logic             out_valid_q;
   logic [WIDTH-1:0] result_q;
   alu_flags_t       flags_q, flags_nxt;

   logic             accept, is_mul, load_alu, load_mul, load, mul_start;
   logic [WIDTH-1:0] mul_prod, ld_res;

   logic [WIDTH:0]   add_full, sub_full;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c, alu_v, alu_err;

   assign add_full = {1'b0, a} + {1'b0, b};
   assign sub_full = {1'b0, a} - {1'b0, b};
   assign shamt    = b[SHW-1:0];

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_err = 1'b0;
      case (op)
         OP_ADD: begin
            alu_res = add_full[MSB:0];
            alu_c   = add_full[WIDTH];
            alu_v   = (a[MSB] == b[MSB]) && (add_full[MSB] != a[MSB]);
         end
         OP_SUB: begin
            alu_res = sub_full[MSB:0];
            alu_c   = ~sub_full[WIDTH];
            alu_v   = (a[MSB] != b[MSB]) && (sub_full[MSB] != a[MSB]);
         end
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         OP_SLL:  alu_res = a << shamt;
         OP_SRA:  alu_res = $signed(a) >>> shamt;
         OP_SRL:  alu_res = a >> shamt;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
         // MUL reaches here only when the multiplier is not built.
         default: alu_err = 1'b1;
      endcase
   end

   assign in_ready = (state == S_IDLE) && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;

`ifdef ALU_MUL_EN
   logic mul_step, mul_done;

   assign is_mul    = (op == OP_MUL);
   assign mul_start = accept && is_mul;
   assign mul_step  = (state == S_MUL) && !mul_done;
   assign load_mul  = (state == S_MUL) && mul_done && (!out_valid_q || out_ready);

   alu_mul_iter #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (a),
      .b       (b),
      .step    (mul_step),
      .done    (mul_done),
      .product (mul_prod)
   );
`else
   assign is_mul    = 1'b0;
   assign mul_start = 1'b0;
   assign load_mul  = 1'b0;
   assign mul_prod  = '0;
`endif

   assign load_alu = accept && !is_mul;
   assign load     = load_alu || load_mul;
   assign ld_res   = load_mul ? mul_prod : alu_res;

   always_comb begin
      flags_nxt       = '0;
      flags_nxt.z     = (ld_res == '0);
      flags_nxt.n     = ld_res[MSB];
      flags_nxt.match = (ld_res == MATCH_VALUE);
      flags_nxt.c     = load_mul ? 1'b0 : alu_c;
      flags_nxt.v     = load_mul ? 1'b0 : alu_v;
      flags_nxt.err   = load_mul ? 1'b0 : alu_err;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (mul_start) state_nxt = S_MUL;
         S_MUL:   if (load_mul)  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // A load in the same edge as a drain keeps out_valid high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
      end else if (load) begin
         out_valid_q <= 1'b1;
         result_q    <= ld_res;
         flags_q     <= flags_nxt;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign z         = flags_q.z;
   assign n         = flags_q.n;
   assign c         = flags_q.c;
   assign v         = flags_q.v;
   assign match     = flags_q.match;
   assign err       = flags_q.err;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe; MUL checks follow the ALU_MUL_EN build option.
module tb_alu_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  op = 4'd0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        z, n, c, v, match, err;

   int errors = 0;
   int checks = 0;

   alu_pipe #(.WIDTH(32), .MATCH_VALUE(32'hABCD)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .z(z), .n(n), .c(c), .v(v), .match(match), .err(err)
   );

   always #5 clk = ~clk;

   // {out_valid, result, z, n, c, v, match, err}
   function automatic logic [63:0] cur();
      return {25'b0, out_valid, result, z, n, c, v, match, err};
   endfunction

   function automatic logic [63:0] pk(input logic vld, input logic [31:0] r, input logic [5:0] f);
      return {25'b0, vld, r, f};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic op1(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      in_valid  = 1'b1;
      op        = o;
      a         = x;
      b         = y;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid  = 1'b0;
   endtask

   initial begin
      logic [63:0] held;
      int          k;

      // reset state (flags order: z n c v match err)
      #12;
      chk("reset_out", cur(), pk(1'b0, 32'h0, 6'b000000));
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("rdy_after_reset", 64'(in_ready), 64'd1);

      op1(4'd0, 32'h7FFF_FFFF, 32'h1);
      chk("add_ovf", cur(), pk(1'b1, 32'h8000_0000, 6'b010100));
      op1(4'd1, 32'd5, 32'd5);
      chk("sub_eq", cur(), pk(1'b1, 32'h0, 6'b101000));
      op1(4'd0, 32'h0000_ABCC, 32'h1);
      chk("add_match", cur(), pk(1'b1, 32'h0000_ABCD, 6'b000010));
      op1(4'd6, 32'h8000_0000, 32'h0000_0024);
      chk("sra_mask", cur(), pk(1'b1, 32'hF800_0000, 6'b010000));
      op1(4'd5, 32'h1234_5678, 32'd32);
      chk("sll_32", cur(), pk(1'b1, 32'h1234_5678, 6'b000000));
      op1(4'd1, 32'd3, 32'd5);
      chk("sub_borrow", cur(), pk(1'b1, 32'hFFFF_FFFE, 6'b010000));
      op1(4'd1, 32'h8000_0000, 32'd1);
      chk("sub_ovf", cur(), pk(1'b1, 32'h7FFF_FFFF, 6'b001100));
      op1(4'd0, 32'hFFFF_FFFF, 32'd1);
      chk("add_carry", cur(), pk(1'b1, 32'h0, 6'b101000));
      op1(4'd8, 32'hFFFF_FFFF, 32'd1);
      chk("slt", cur(), pk(1'b1, 32'd1, 6'b000000));
      op1(4'd9, 32'hFFFF_FFFF, 32'd1);
      chk("sltu", cur(), pk(1'b1, 32'd0, 6'b100000));
      op1(4'd7, 32'h8000_0000, 32'd4);
      chk("srl", cur(), pk(1'b1, 32'h0800_0000, 6'b000000));
      op1(4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00);
      chk("and", cur(), pk(1'b1, 32'hF000_F000, 6'b010000));
      op1(4'd3, 32'hF0F0_F0F0, 32'hFF00_FF00);
      chk("or", cur(), pk(1'b1, 32'hFFF0_FFF0, 6'b010000));
      op1(4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00);
      chk("xor", cur(), pk(1'b1, 32'h0FF0_0FF0, 6'b000000));
      op1(4'd13, 32'h1234, 32'h5678);
      chk("illegal", cur(), pk(1'b1, 32'h0, 6'b100001));

      // streaming: one result per clock, in order
      in_valid  = 1'b1;
      out_ready = 1'b1;
      op        = 4'd0;
      a         = 32'd0;
      b         = 32'd100;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         chk($sformatf("stream%0d", i), cur(), pk(1'b1, 32'(i + 100), 6'b000000));
         chk($sformatf("stream_rdy%0d", i), 64'(in_ready), 64'd1);
         a = 32'(i + 1);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("drain_clears", 64'(out_valid), 64'd0);

      // backpressure: result pending and held
      in_valid  = 1'b1;
      op        = 4'd0;
      a         = 32'd10;
      b         = 32'd20;
      out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid  = 1'b0;
      a         = 32'hDEAD_BEEF;
      held      = pk(1'b1, 32'd30, 6'b000000);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("stall_rdy%0d", i), 64'(in_ready), 64'd0);
         chk($sformatf("stall_hold%0d", i), cur(), held);
         @(posedge clk); #1;
      end
      in_valid  = 1'b1;
      op        = 4'd1;
      a         = 32'd7;
      b         = 32'd2;
      out_ready = 1'b1;
      #1;
      chk("drain_rdy", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("drain_load", cur(), pk(1'b1, 32'd5, 6'b001000));

`ifdef ALU_MUL_EN
      op1(4'd10, 32'hFFFF_FFFF, 32'd3);
      k = 0;
      while (!out_valid && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      chk("mul_latency", 64'(k), 64'd32);
      chk("mul_result", cur(), pk(1'b1, 32'hFFFF_FFFD, 6'b010000));
      @(posedge clk); #1;

      op1(4'd10, 32'd1234, 32'd5678);
      chk("mul_busy_rdy", 64'(in_ready), 64'd0);
      repeat (10) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mul_rst_out", cur(), pk(1'b0, 32'h0, 6'b000000));
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("mul_rst_rdy", 64'(in_ready), 64'd1);
      repeat (40) @(posedge clk);
      #1;
      chk("mul_rst_discard", 64'(out_valid), 64'd0);
`else
      op1(4'd10, 32'hFFFF_FFFF, 32'd3);
      chk("mul_illegal", cur(), pk(1'b1, 32'h0, 6'b100001));
      k = 0;
      chk("mul_rdy", 64'(in_ready), 64'd1);

      in_valid  = 1'b1;
      op        = 4'd0;
      a         = 32'd1;
      b         = 32'd2;
      out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("rst_pending", cur(), pk(1'b0, 32'h0, 6'b000000));
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("rst_rdy", 64'(in_ready), 64'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
